count_step_decoder: RTL

//  Receive-side companion to the 4-bit up/down counter. Samples the counter's q bus and

---
 rtl/count_step_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/count_step_decoder.sv
// count_step_decoder
//   Watches the q bus of a free-running up/down counter and turns every sampled change into
//   step/wrap pulses. It keeps a saturating signed position and the direction of the last
//   valid step. Illegal jumps raise err; ERR_LIMIT of them in a row latch the block into
//   FAULT until clr or reset.
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   clr      synchronous clear back to UNLOCKED (wins over en)
//   en       sample strobe for q_in
//   q_in     observed counter value
//   step_up  1-cycle pulse, +1 step decoded
//   step_dn  1-cycle pulse, -1 step decoded
//   wrap_up  1-cycle pulse, max -> 0 step
//   wrap_dn  1-cycle pulse, 0 -> max step
//   dir      direction of last valid step (1 = up)
//   pos      signed two's-complement position
//   err      1-cycle pulse, illegal jump
//   locked   high in LOCKED
//   fault    high in FAULT
module count_step_decoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned POS_WIDTH = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 wrap_up,
  output logic                 wrap_dn,
  output logic                 dir,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 err,
  output logic                 locked,
  output logic                 fault
);

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StLocked   = 2'd1,
    StFault    = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]     DeltaOne = WIDTH'(1);
  localparam logic [WIDTH-1:0]     AllOnes  = '1;
  localparam logic [WIDTH-1:0]     AllZeros = '0;
  localparam logic [POS_WIDTH-1:0] PosOne   = POS_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0] PosMax   = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] PosMin   = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic [2:0]           ErrLimit = 3'(ERR_LIMIT);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [2:0]           err_cnt_q, err_cnt_d;
  logic                 dir_q, dir_d;
  logic                 step_up_q, step_up_d;
  logic                 step_dn_q, step_dn_d;
  logic                 wrap_up_q, wrap_up_d;
  logic                 wrap_dn_q, wrap_dn_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     delta;
  logic [2:0]           err_cnt_inc;

  // Modular difference: the counter bus wraps, so 0 - max is a legal +1 step.
  assign delta       = q_in - prev_q;
  assign err_cnt_inc = err_cnt_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;
    dir_d     = dir_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    err_d     = 1'b0;

    if (clr) begin
      state_d   = StUnlocked;
      prev_d    = '0;
      pos_d     = '0;
      err_cnt_d = '0;
      dir_d     = 1'b0;
    end else if (en) begin
      case (state_q)
        StUnlocked: begin
          // First sample only establishes the reference value.
          prev_d  = q_in;
          state_d = StLocked;
        end
        StLocked: begin
          prev_d = q_in;
          if (delta == AllZeros) begin
            // Hold: nothing changes.
          end else if (delta == DeltaOne) begin
            step_up_d = 1'b1;
            wrap_up_d = (prev_q == AllOnes);
            dir_d     = 1'b1;
            err_cnt_d = '0;
            if (pos_q != PosMax) pos_d = pos_q + PosOne;
          end else if (delta == AllOnes) begin
            step_dn_d = 1'b1;
            wrap_dn_d = (prev_q == AllZeros);
            dir_d     = 1'b0;
            err_cnt_d = '0;
            if (pos_q != PosMin) pos_d = pos_q - PosOne;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = err_cnt_inc;
            if (err_cnt_inc == ErrLimit) state_d = StFault;
          end
        end
        StFault: begin
          // Sticky until clr or reset.
        end
        default: state_d = StUnlocked;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StUnlocked;
      prev_q    <= '0;
      pos_q     <= '0;
      err_cnt_q <= '0;
      dir_q     <= 1'b0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
      dir_q     <= dir_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      err_q     <= err_d;
    end
  end

  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;
  assign dir     = dir_q;
  assign pos     = pos_q;
  assign err     = err_q;
  assign locked  = (state_q == StLocked);
  assign fault   = (state_q == StFault);

endmodule
